// File: rtl/rr_issue_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_issue_arbiter_pkg
// Purpose  : Shared constants and helpers for the round-robin issue arbiter.
//            MAX_REQ caps the requester count; grant_idx_width() sizes the
//            grant index so that it is never narrower than one bit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package rr_issue_arbiter_pkg;

   localparam int MAX_REQ = 16;

   // Width of an index able to address n requesters (minimum 1 bit).
   function automatic int grant_idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_issue_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_issue_arbiter_if
// Purpose  : Bundles the N upstream valid/ready channels, the flush strobe and
//            the single downstream valid/ready channel of the arbiter.
// Ports    : flush     - pipeline flush
//            req_valid - per-requester valid        req_ready - one-hot ready
//            req_data  - per-requester payload (T)
//            valid_out - output slot valid          ready_out - consumer ready
//            data_out  - registered payload (T)     grant_id  - source index
// Modports : master - the surrounding pipeline (drives requests, consumes)
//            slave  - the arbiter itself
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface rr_issue_arbiter_if
   import rr_issue_arbiter_pkg::*;
#(
   parameter type T = logic,
   parameter int  N = 4
);
   localparam int IDW = grant_idx_width(N);

   logic           flush;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   T               req_data [N];
   logic           valid_out;
   logic           ready_out;
   T               data_out;
   logic [IDW-1:0] grant_id;

   modport master (
      output flush, req_valid, req_data, ready_out,
      input  req_ready, valid_out, data_out, grant_id
   );

   modport slave (
      input  flush, req_valid, req_data, ready_out,
      output req_ready, valid_out, data_out, grant_id
   );

endinterface
`default_nettype wire

// File: rtl/rr_issue_arbiter_pick.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first set bit of
//            req_vec searching upward from ptr, wrapping modulo N (N need not
//            be a power of two).
// Ports    : req_vec - request vector        ptr - highest-priority index
//            sel     - selected index        any - at least one request set
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rr_pick
   import rr_issue_arbiter_pkg::*;
#(
   parameter  int N   = 4,
   localparam int IDW = grant_idx_width(N)
) (
   input  wire logic [N-1:0]   req_vec,
   input  wire logic [IDW-1:0] ptr,
   output      logic [IDW-1:0] sel,
   output      logic           any
);

   localparam int unsigned C_N = N;

   // (base + off) mod N, valid for base < N and off < N.
   function automatic logic [IDW-1:0] mod_add(input logic [IDW-1:0] base,
                                              input int unsigned    off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= C_N) begin
         sum = sum - C_N;
      end
      return sum[IDW-1:0];
   endfunction

   logic [N-1:0]   w_rot;
   logic [IDW-1:0] w_off;

   // Rotate so that position 0 of w_rot is the current priority holder.
   always_comb begin
      w_rot = '0;
      for (int k = 0; k < N; k++) begin
         w_rot[k] = req_vec[mod_add(ptr, 32'(k))];
      end
   end

   // Priority encode: scanning downward leaves the lowest set offset.
   always_comb begin
      w_off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = IDW'(k);
         end
      end
   end

   // Un-rotate the offset back into an absolute requester index.
   assign sel = mod_add(ptr, 32'(w_off));
   assign any = |req_vec;

endmodule
`default_nettype wire

// File: rtl/rr_issue_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_issue_arbiter
// Purpose  : Shares one downstream channel among N valid/ready producers.
//            Each cycle the slot can load, one requester is picked round-robin
//            and its payload captured into a single registered output slot.
//            One cycle of latency, one transfer per cycle sustained.
// Ports    : clk   - clock
//            reset - synchronous active-high reset
//            bus   - rr_issue_arbiter_if.slave (requests, flush, output slot)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rr_issue_arbiter
   import rr_issue_arbiter_pkg::*;
#(
   parameter  type T   = logic,
   parameter  int  N   = 4,
   localparam int  IDW = grant_idx_width(N)
) (
   input wire logic         clk,
   input wire logic         reset,
   rr_issue_arbiter_if.slave bus
);

   // Output slot and round-robin pointer
   logic           r_slot_v;
   T               r_slot_data;
   logic [IDW-1:0] r_slot_id;
   logic [IDW-1:0] r_rr_ptr;

   logic           w_load_en;
   logic           w_any;
   logic           w_take;
   logic [IDW-1:0] w_sel;
   logic [IDW-1:0] w_ptr_nxt;
   logic [N-1:0]   w_req_ready;

   rr_pick #(
      .N (N)
   ) u_pick (
      .req_vec (bus.req_valid),
      .ptr     (r_rr_ptr),
      .sel     (w_sel),
      .any     (w_any)
   );

   // The slot can take a new payload when it is empty or being drained this
   // cycle; a flush blocks acceptance outright.
   assign w_load_en = !bus.flush && (!r_slot_v || bus.ready_out);
   assign w_take    = w_load_en && w_any;

   // Pointer moves just past the winner; explicit wrap handles N != 2^k.
   assign w_ptr_nxt = (w_sel == IDW'(N - 1)) ? '0 : w_sel + 1'b1;

   // Ready is also held low during reset so no requester believes a payload
   // was accepted that the reset is about to discard.
   always_comb begin
      w_req_ready = '0;
      for (int i = 0; i < N; i++) begin
         w_req_ready[i] = !reset && w_take && (w_sel == IDW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_slot_v    <= 1'b0;
         r_slot_data <= '0;
         r_slot_id   <= '0;
         r_rr_ptr    <= '0;
      end else if (bus.flush) begin
         // Data and id keep their stale values; only the valid drops.
         r_slot_v <= 1'b0;
      end else if (w_load_en) begin
         if (w_any) begin
            r_slot_data <= bus.req_data[w_sel];
            r_slot_id   <= w_sel;
            r_slot_v    <= 1'b1;
            r_rr_ptr    <= w_ptr_nxt;
         end else begin
            r_slot_v <= 1'b0;
         end
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.valid_out = r_slot_v;
   assign bus.data_out  = r_slot_data;
   assign bus.grant_id  = r_slot_id;

   a_ready_onehot : assert property (@(posedge clk) disable iff (reset)
      $onehot0(w_req_ready));

   a_stall_stable : assert property (@(posedge clk) disable iff (reset)
      (!reset && bus.valid_out && !bus.ready_out && !bus.flush)
      |=> ($stable(bus.data_out) && $stable(bus.grant_id)));

endmodule
`default_nettype wire

// File: tb/tb_rr_issue_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_rr_issue_arbiter
// Purpose  : Self-checking bench for rr_issue_arbiter (N=4 main instance plus
//            an N=3 instance for non-power-of-two wrap). A reference model
//            predicts ready and loaded payloads into a scoreboard queue; a
//            separate monitor pops and compares on every downstream accept.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rr_issue_arbiter;
   import rr_issue_arbiter_pkg::*;

   typedef struct packed {
      logic [7:0] val;
      logic [3:0] tag;
   } pkt_t;

   typedef struct {
      int   id;
      pkt_t d;
   } exp_t;

   localparam int N  = 4;
   localparam int N3 = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rr_issue_arbiter_if #(.T(pkt_t), .N(N))  bus4 ();
   rr_issue_arbiter_if #(.T(pkt_t), .N(N3)) bus3 ();

   rr_issue_arbiter #(.T(pkt_t), .N(N))  dut4 (.clk(clk), .reset(reset), .bus(bus4));
   rr_issue_arbiter #(.T(pkt_t), .N(N3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Reference model: slot occupancy, priority pointer, expected ready and
   // the queue of payloads that will appear downstream.
   //---------------------------------------------------------------------------
   bit           m_v;
   int           m_ptr;
   int           m_pick;
   bit           m_load;
   logic [N-1:0] m_rv;
   logic [N-1:0] m_exp_rdy;
   int           m_wait [N];
   exp_t         sb_q [$];

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            m_v   = 1'b0;
            m_ptr = 0;
            sb_q.delete();
            for (int i = 0; i < N; i++) m_wait[i] = 0;
         end else begin
            m_rv = bus4.req_valid;
            check("valid_out", 32'(bus4.valid_out), 32'(m_v));
            m_load = !bus4.flush && (!m_v || bus4.ready_out);
            m_pick = -1;
            if (m_load) begin
               for (int k = 0; k < N; k++) begin
                  if (m_pick < 0 && m_rv[(m_ptr + k) % N]) m_pick = (m_ptr + k) % N;
               end
            end
            m_exp_rdy = '0;
            if (m_pick >= 0) m_exp_rdy[m_pick] = 1'b1;
            check("req_ready", 32'(bus4.req_ready), 32'(m_exp_rdy));

            if (m_pick >= 0) begin
               // Fairness: a waiting requester is served within N loads.
               check("fair_wait_lt_n", 32'(m_wait[m_pick] < N), 32'd1);
               for (int i = 0; i < N; i++) begin
                  if (i == m_pick || !m_rv[i]) m_wait[i] = 0;
                  else                         m_wait[i]++;
               end
               sb_q.push_back('{id: m_pick, d: bus4.req_data[m_pick]});
               m_ptr = (m_pick + 1) % N;
            end else begin
               for (int i = 0; i < N; i++) if (!m_rv[i]) m_wait[i] = 0;
            end

            if (bus4.flush)  m_v = 1'b0;
            else if (m_load) m_v = (m_pick >= 0);
         end
      end
   end

   //---------------------------------------------------------------------------
   // Monitor: every downstream accept is compared with the scoreboard head;
   // a flushed slot is dropped from the queue.
   //---------------------------------------------------------------------------
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && bus4.valid_out && (bus4.flush || bus4.ready_out)) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_empty: got output with no expected entry at %0t", $time);
            end else begin
               mon_e = sb_q.pop_front();
               if (!bus4.flush) begin
                  check("sb_grant_id", 32'(bus4.grant_id), 32'(mon_e.id));
                  check("sb_data_out", 32'(bus4.data_out), 32'(mon_e.d));
               end
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data4();
      for (int i = 0; i < N; i++) bus4.req_data[i] = '{val: 8'(8'h10 + i), tag: 4'(i)};
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      bus4.flush     = 1'b0;
      bus4.req_valid = '0;
      bus4.ready_out = 1'b0;
      bus3.flush     = 1'b0;
      bus3.req_valid = '0;
      bus3.ready_out = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [N-1:0] hs;
   logic [N-1:0] rv;

   initial begin
      reset = 1'b1;
      set_data4();
      for (int i = 0; i < N3; i++) bus3.req_data[i] = '{val: 8'(8'h30 + i), tag: 4'(i)};

      // Reset state
      do_reset();
      check("rst_valid_out", 32'(bus4.valid_out), 32'd0);
      check("rst_data_out",  32'(bus4.data_out),  32'd0);
      check("rst_grant_id",  32'(bus4.grant_id),  32'd0);

      // All requesting, consumer always ready: 0,1,2,3,0,1
      bus4.req_valid = 4'b1111;
      bus4.ready_out = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("t1_grant", 32'(bus4.grant_id), 32'(k % 4));
         check("t1_valid", 32'(bus4.valid_out), 32'd1);
      end

      // Sparse requests: 1,3,1,3
      do_reset();
      set_data4();
      bus4.req_valid = 4'b1010;
      bus4.ready_out = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t2_grant", 32'(bus4.grant_id), (k % 2 == 0) ? 32'd1 : 32'd3);
      end

      // Stall holding requester 2 payload 0xA5, then resume grants 3
      do_reset();
      set_data4();
      bus4.req_data[2] = '{val: 8'hA5, tag: 4'd2};
      bus4.req_valid   = 4'b0100;
      bus4.ready_out   = 1'b0;
      tick();
      bus4.req_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t3_hold_data",  32'(bus4.data_out.val), 32'hA5);
         check("t3_hold_grant", 32'(bus4.grant_id), 32'd2);
         check("t3_no_ready",   32'(bus4.req_ready), 32'd0);
      end
      bus4.ready_out = 1'b1;
      tick();
      check("t3_next_grant", 32'(bus4.grant_id), 32'd3);

      // Flush wins over ready_out; requester 0 granted afterwards
      do_reset();
      set_data4();
      bus4.req_valid = 4'b0001;
      bus4.ready_out = 1'b1;
      tick();
      bus4.flush = 1'b1;
      #1;
      check("t4_flush_ready", 32'(bus4.req_ready), 32'd0);
      tick();
      bus4.flush = 1'b0;
      check("t4_flush_valid", 32'(bus4.valid_out), 32'd0);
      tick();
      check("t4_after_grant", 32'(bus4.grant_id), 32'd0);
      check("t4_after_valid", 32'(bus4.valid_out), 32'd1);

      // Reset while stalled with a valid slot
      do_reset();
      set_data4();
      bus4.req_valid = 4'b0100;
      bus4.ready_out = 1'b0;
      tick();
      bus4.req_valid = '0;
      reset = 1'b1;
      tick();
      check("t6_rst_valid", 32'(bus4.valid_out), 32'd0);
      check("t6_rst_grant", 32'(bus4.grant_id),  32'd0);
      check("t6_rst_data",  32'(bus4.data_out),  32'd0);
      tick();
      reset = 1'b0;
      bus4.req_valid = 4'b0110;
      tick();
      check("t6_first_grant", 32'(bus4.grant_id), 32'd1);

      // Randomized traffic honouring the hold-until-ready obligation
      do_reset();
      rv = '0;
      hs = '0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!rv[i] || hs[i]) begin
               rv[i] = ($urandom_range(0, 2) != 0);
               bus4.req_data[i] = '{val: 8'($urandom), tag: 4'(i)};
            end
         end
         bus4.req_valid = rv;
         bus4.ready_out = ($urandom_range(0, 3) != 0);
         bus4.flush     = ($urandom_range(0, 15) == 0);
         #2;
         hs = bus4.req_ready;
         tick();
      end
      bus4.flush     = 1'b0;
      bus4.req_valid = '0;
      bus4.ready_out = 1'b1;
      tick();
      tick();

      // N=3 wrap: 0,1,2,0,1,2
      do_reset();
      bus3.req_valid = 3'b111;
      bus3.ready_out = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("t5_n3_grant", 32'(bus3.grant_id), 32'(k % 3));
         check("t5_n3_valid", 32'(bus3.valid_out), 32'd1);
      end

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
